// File: rtl/io_uart_tx_responder_pkg.sv
// Shared constants for the IO UART transmit responder: register map,
// STATUS bit layout, TX FSM encoding and the baud divider clamp.
package io_uart_tx_responder_pkg;

  localparam int IO_SEL_BIT = 22;

  localparam logic [2:0] OFF_DATA     = 3'd0;
  localparam logic [2:0] OFF_STATUS   = 3'd1;
  localparam logic [2:0] OFF_BAUD_DIV = 3'd2;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_DROP_LSB  = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // A divider of zero would stall the bit timer, so it behaves as one.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/io_uart_tx_responder_fifo.sv
// Byte FIFO for the UART transmitter; dout shows the head entry so a pop
// consumes it in the same cycle.
module io_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        push_ok;
  logic        pop_ok;

  assign count   = wptr - rptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + (AW+1)'(1'b1);
      if (pop_ok)  rptr <= rptr + (AW+1)'(1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push_ok) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/io_uart_tx_responder.sv
// Memory-mapped IO responder: DATA/STATUS/BAUD_DIV register page feeding a
// byte FIFO that is serialised as 8N1 frames on uart_tx.
module io_uart_tx_responder #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd217,
  parameter int          IO_SEL_BIT  = io_uart_tx_responder_pkg::IO_SEL_BIT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_wr,
  output logic [31:0] io_rdata,
  output logic        uart_tx,
  output logic        tx_idle
);

  import io_uart_tx_responder_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [2:0]  off;
  logic        wr_sel;
  logic        wr_data;
  logic        wr_status;
  logic        wr_div;
  logic [7:0]  fifo_dout;
  logic [AW:0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push_ok;
  logic        at_boundary;
  logic        pop;
  logic        baud_done;
  logic [15:0] reload;
  logic [3:0]  count4;
  logic        unused_bits;

  tx_state_e   state;
  logic [7:0]  sh;
  logic [2:0]  bit_idx;
  logic [15:0] baud_cnt;
  logic [15:0] div;
  logic [7:0]  drop_cnt;

  assign off         = io_addr[4:2];
  assign wr_sel      = io_wr & io_addr[IO_SEL_BIT];
  assign wr_data     = wr_sel & (off == OFF_DATA);
  assign wr_status   = wr_sel & (off == OFF_STATUS);
  assign wr_div      = wr_sel & (off == OFF_BAUD_DIV);
  assign push_ok     = wr_data & ~fifo_full;
  assign baud_done   = (baud_cnt == 16'd0);
  assign reload      = div - 16'd1;
  assign at_boundary = (state == TX_IDLE) || ((state == TX_STOP) && baud_done);
  assign pop         = at_boundary & ~fifo_empty;
  assign count4      = 4'(fifo_count);
  assign unused_bits = ^io_addr ^ ^io_wdata;

  io_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (wr_data),
    .pop    (pop),
    .din    (io_wdata[7:0]),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Loads have no strobe, so read data is a pure decode of address and state.
  always_comb begin
    io_rdata = 32'd0;
    case (off)
      OFF_STATUS: begin
        io_rdata[ST_BUSY]              = (state != TX_IDLE);
        io_rdata[ST_FULL]              = fifo_full;
        io_rdata[ST_EMPTY]             = fifo_empty;
        io_rdata[ST_COUNT_LSB +: 4]    = count4;
        io_rdata[ST_DROP_LSB +: 8]     = drop_cnt;
      end
      OFF_BAUD_DIV: io_rdata[15:0] = div;
      default:      io_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div      <= clamp_div(DEFAULT_DIV);
      drop_cnt <= 8'd0;
    end else begin
      if (wr_div) div <= clamp_div(io_wdata[15:0]);
      if (wr_status) begin
        drop_cnt <= 8'd0;
      end else if (wr_data && fifo_full && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // tx_idle looks ahead one edge so it rises together with the return to IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= TX_IDLE;
      sh       <= 8'd0;
      bit_idx  <= 3'd0;
      baud_cnt <= 16'd0;
      uart_tx  <= 1'b1;
      tx_idle  <= 1'b1;
    end else begin
      tx_idle <= at_boundary & fifo_empty & ~push_ok;
      case (state)
        TX_IDLE: begin
          uart_tx <= 1'b1;
          if (!fifo_empty) begin
            sh       <= fifo_dout;
            baud_cnt <= reload;
            state    <= TX_START;
            uart_tx  <= 1'b0;
          end
        end
        TX_START: begin
          if (baud_done) begin
            state    <= TX_DATA;
            bit_idx  <= 3'd0;
            uart_tx  <= sh[0];
            baud_cnt <= reload;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (!baud_done) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else if (bit_idx == 3'd7) begin
            state    <= TX_STOP;
            uart_tx  <= 1'b1;
            baud_cnt <= reload;
          end else begin
            sh       <= {1'b0, sh[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            uart_tx  <= sh[1];
            baud_cnt <= reload;
          end
        end
        TX_STOP: begin
          if (!baud_done) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else if (!fifo_empty) begin
            sh       <= fifo_dout;
            baud_cnt <= reload;
            state    <= TX_START;
            uart_tx  <= 1'b0;
          end else begin
            state    <= TX_IDLE;
            uart_tx  <= 1'b1;
          end
        end
        default: begin
          state   <= TX_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule
